// File: rtl/mult_arb_pkg.sv
// Shared types and default constants for the multiplier arbiter.
package mult_arb_pkg;

    typedef enum logic [2:0] {
        SETTLE,
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    localparam int unsigned NREQ_DEF       = 4;
    localparam int unsigned WIDTH_DEF      = 4;
    localparam int unsigned SETTLE_CYC_DEF = 10;
    localparam int unsigned TIMEOUT_DEF    = 16;

endpackage

// File: rtl/mult_arbiter_if.sv
// Client request/response bus plus multiplier handshake for mult_arbiter.
interface mult_arbiter_if
    import mult_arb_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_mplier;
    logic [NREQ*WIDTH-1:0] req_mcand;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       resp_valid;
    logic [2*WIDTH-1:0]    resp_result;
    logic                  resp_err;
    logic                  mult_st;
    logic [WIDTH-1:0]      mult_mplier;
    logic [WIDTH-1:0]      mult_mcand;
    logic                  mult_done;
    logic [2*WIDTH-1:0]    mult_result;

    // Arbiter side
    modport slave (
        input  req, req_mplier, req_mcand, mult_done, mult_result,
        output gnt, resp_valid, resp_result, resp_err, mult_st, mult_mplier, mult_mcand
    );

    // Clients and multiplier side
    modport master (
        output req, req_mplier, req_mcand, mult_done, mult_result,
        input  gnt, resp_valid, resp_result, resp_err, mult_st, mult_mplier, mult_mcand
    );
endinterface

// File: rtl/mult_arb_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr, wrapping upward.
module mult_arb_rr_pick #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  win_oh_c_o,
    output logic [PTR_W-1:0] win_idx_c_o,
    output logic             win_any_c_o
);
    logic [PTR_W-1:0] cand;
    logic             found;

    always_comb begin
        win_oh_c_o  = '0;
        win_idx_c_o = '0;
        found       = 1'b0;
        cand        = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = PTR_W'((32'(ptr_i) + k) % NREQ);
            if (!found && req_i[cand]) begin
                found            = 1'b1;
                win_idx_c_o      = cand;
                win_oh_c_o[cand] = 1'b1;
            end
        end
    end

    assign win_any_c_o = |req_i;

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one st/done multiplier between NREQ clients.
// Optional WAIT timeout with error response: define MULT_ARB_TIMEOUT_EN.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned NREQ       = NREQ_DEF,
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    mult_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
    localparam int unsigned PW    = 2 * WIDTH;

    if (NREQ < 2 || NREQ > 8 || SETTLE_CYC < 1 || TIMEOUT < 1) begin : g_param_chk
        $error("mult_arbiter: parameter out of range");
    end

    state_e           state_q, state_d;
    logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  resp_valid_q, resp_valid_d;
    logic [PW-1:0]    resp_result_q, resp_result_d;
    logic             mult_st_q, mult_st_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;

    logic [NREQ-1:0]  win_oh_c;
    logic [PTR_W-1:0] win_idx_c;
    logic             win_any_c;
    logic [WIDTH-1:0] mplier_arr [NREQ];
    logic [WIDTH-1:0] mcand_arr  [NREQ];

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            resp_err_q, resp_err_d;
`endif

    for (genvar g = 0; g < NREQ; g++) begin : g_ops
        assign mplier_arr[g] = bus.req_mplier[g*WIDTH +: WIDTH];
        assign mcand_arr[g]  = bus.req_mcand[g*WIDTH +: WIDTH];
    end

    mult_arb_rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i       (bus.req),
        .ptr_i       (rr_ptr_q),
        .win_oh_c_o  (win_oh_c),
        .win_idx_c_o (win_idx_c),
        .win_any_c_o (win_any_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        settle_cnt_d  = settle_cnt_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        gnt_d         = gnt_q;
        resp_valid_d  = '0;
        resp_result_d = resp_result_q;
        mult_st_d     = 1'b0;
        mplier_d      = mplier_q;
        mcand_d       = mcand_q;
`ifdef MULT_ARB_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        resp_err_d    = 1'b0;
`endif
        unique case (state_q)
            SETTLE: begin
                if (settle_cnt_q == SET_W'(SETTLE_CYC - 1)) begin
                    settle_cnt_d = '0;
                    state_d      = IDLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + SET_W'(1);
                end
            end
            IDLE: begin
                if (win_any_c) begin
                    owner_d   = win_idx_c;
                    gnt_d     = win_oh_c;
                    mplier_d  = mplier_arr[win_idx_c];
                    mcand_d   = mcand_arr[win_idx_c];
                    mult_st_d = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            WAIT: begin
                if (bus.mult_done) begin
                    resp_result_d = bus.mult_result;
                    resp_valid_d  = gnt_q;
                    state_d       = RESP;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    resp_result_d = '0;
                    resp_valid_d  = gnt_q;
                    resp_err_d    = 1'b1;
                    state_d       = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                end
`endif
            end
            RESP: begin
                gnt_d    = '0;
                rr_ptr_d = (owner_q == PTR_W'(NREQ - 1)) ? '0 : owner_q + PTR_W'(1);
                state_d  = IDLE;
`ifdef MULT_ARB_TIMEOUT_EN
                // A timed-out multiplier may still be running; flush it first
                if (resp_err_q) state_d = SETTLE;
`endif
            end
            default: state_d = SETTLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SETTLE;
            settle_cnt_q  <= '0;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            gnt_q         <= '0;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            mult_st_q     <= 1'b0;
            mplier_q      <= '0;
            mcand_q       <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
            wait_cnt_q    <= '0;
            resp_err_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            gnt_q         <= gnt_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            mult_st_q     <= mult_st_d;
            mplier_q      <= mplier_d;
            mcand_q       <= mcand_d;
`ifdef MULT_ARB_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            resp_err_q    <= resp_err_d;
`endif
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_result = resp_result_q;
    assign bus.mult_st     = mult_st_q;
    assign bus.mult_mplier = mplier_q;
    assign bus.mult_mcand  = mcand_q;
`ifdef MULT_ARB_TIMEOUT_EN
    assign bus.resp_err    = resp_err_q;
`else
    assign bus.resp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural shift-add multiplier (9-cycle latency).
module tb_mult_arbiter;
    import mult_arb_pkg::*;

    localparam int unsigned NR   = NREQ_DEF;
    localparam int unsigned W    = WIDTH_DEF;
    localparam int unsigned PW   = 2 * W;
    localparam int unsigned MLAT = 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_arbiter_if #(.NREQ(NR), .WIDTH(W)) bus ();

    mult_arbiter #(
        .NREQ       (NR),
        .WIDTH      (W),
        .SETTLE_CYC (SETTLE_CYC_DEF),
        .TIMEOUT    (TIMEOUT_DEF)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Multiplier model: no reset, ignores st while busy, done MLAT cycles after st sample
    logic          m_busy = 1'b0;
    int unsigned   m_cnt  = 0;
    logic [PW-1:0] m_prod = '0;
    bit            m_mute = 1'b0;

    always @(posedge clk) begin
        bus.mult_done <= 1'b0;
        if (m_busy) begin
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                if (!m_mute) begin
                    bus.mult_done   <= 1'b1;
                    bus.mult_result <= m_prod;
                end
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (bus.mult_st === 1'b1) begin
            m_busy <= 1'b1;
            m_cnt  <= MLAT;
            m_prod <= PW'(bus.mult_mplier) * PW'(bus.mult_mcand);
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int st_cnt = 0;
    int rv_cnt = 0;
    int t0 = 0;
    bit auto_drop = 1'b1;

    int            q_idx[$];
    logic [PW-1:0] q_res[$];
    logic          q_err[$];
    int            q_cyc[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int idx_at(input int i);
        if (i < q_idx.size()) return q_idx[i];
        return -1;
    endfunction

    function automatic logic [PW-1:0] res_at(input int i);
        if (i < q_res.size()) return q_res[i];
        return '1;
    endfunction

    function automatic logic err_at(input int i);
        if (i < q_err.size()) return q_err[i];
        return 1'bx;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < q_cyc.size()) return q_cyc[i];
        return -1;
    endfunction

    task automatic clear_log();
        q_idx.delete();
        q_res.delete();
        q_err.delete();
        q_cyc.delete();
    endtask

    // One cycle: sample at negedge, log responses, apply the client drop rule
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.mult_st === 1'b1) st_cnt++;
        if (bus.resp_valid !== '0) begin
            rv_cnt++;
            for (int i = 0; i < int'(NR); i++) begin
                if (((bus.resp_valid >> i) & NR'(1)) != '0) q_idx.push_back(i);
            end
            q_res.push_back(bus.resp_result);
            q_err.push_back(bus.resp_err);
            q_cyc.push_back(cyc);
            if (auto_drop) bus.req = bus.req & ~bus.resp_valid;
        end
    endtask

    task automatic wait_resp(input int n, input int budget, input string tag);
        int k = 0;
        while (q_idx.size() < n && k < budget) begin
            tick();
            k++;
        end
        check_val(tag, 32'(q_idx.size() >= n), 32'd1);
    endtask

    task automatic set_ops(input int c, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_mplier[c*W +: W] = a;
        bus.req_mcand[c*W +: W]  = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        clear_log();
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({bus.gnt, bus.resp_valid, bus.resp_result, bus.resp_err,
                    bus.mult_st, bus.mult_mplier, bus.mult_mcand});
    endfunction

    initial begin
        int  n;
        bit  seen;
        bus.req        = '0;
        bus.req_mplier = '0;
        bus.req_mcand  = '0;

        tick();
        check_val("rst_outputs", all_outs(), 32'd0);

        // Single client, 3*5
        do_reset();
        repeat (12) tick();
        set_ops(0, 4'd3, 4'd5);
        st_cnt = 0;
        rv_cnt = 0;
        t0 = cyc;
        bus.req = 4'b0001;
        tick();
        check_val("t1_gnt_issue", 32'(bus.gnt), 32'h1);
        check_val("t1_st_issue", 32'(bus.mult_st), 32'h1);
        check_val("t1_ops", 32'({bus.mult_mplier, bus.mult_mcand}), 32'h35);
        wait_resp(1, 40, "t1_resp_tmo");
        check_val("t1_idx", 32'(idx_at(0)), 32'd0);
        check_val("t1_result", 32'(res_at(0)), 32'h0F);
        check_val("t1_err", 32'(err_at(0)), 32'd0);
        check_val("t1_latency", 32'(cyc_at(0) - t0), 32'd12);
        repeat (3) tick();
        check_val("t1_st_pulses", 32'(st_cnt), 32'd1);
        check_val("t1_rv_cycles", 32'(rv_cnt), 32'd1);
        check_val("t1_gnt_drop", 32'(bus.gnt), 32'h0);

        // All four at once after reset
        do_reset();
        set_ops(0, 4'd2, 4'd3);
        set_ops(1, 4'd4, 4'd5);
        set_ops(2, 4'd9, 4'd7);
        set_ops(3, 4'd15, 4'd15);
        bus.req = 4'b1111;
        wait_resp(4, 200, "t2_resp_tmo");
        check_val("t2_order0", 32'(idx_at(0)), 32'd0);
        check_val("t2_order1", 32'(idx_at(1)), 32'd1);
        check_val("t2_order2", 32'(idx_at(2)), 32'd2);
        check_val("t2_order3", 32'(idx_at(3)), 32'd3);
        check_val("t2_res0", 32'(res_at(0)), 32'h06);
        check_val("t2_res1", 32'(res_at(1)), 32'h14);
        check_val("t2_res2", 32'(res_at(2)), 32'h3F);
        check_val("t2_res3", 32'(res_at(3)), 32'hE1);
        tick();

        // Clients 0 and 2 re-request continuously
        clear_log();
        auto_drop = 1'b0;
        set_ops(0, 4'd3, 4'd4);
        set_ops(2, 4'd5, 4'd5);
        bus.req = 4'b0101;
        wait_resp(4, 200, "t3_resp_tmo");
        bus.req = '0;
        auto_drop = 1'b1;
        check_val("t3_order0", 32'(idx_at(0)), 32'd0);
        check_val("t3_order1", 32'(idx_at(1)), 32'd2);
        check_val("t3_order2", 32'(idx_at(2)), 32'd0);
        check_val("t3_order3", 32'(idx_at(3)), 32'd2);
        check_val("t3_res1", 32'(res_at(1)), 32'h19);
        check_val("t3_res2", 32'(res_at(2)), 32'h0C);
        tick();

        // Reset while waiting on the multiplier
        clear_log();
        set_ops(0, 4'd3, 4'd5);
        bus.req = 4'b0001;
        repeat (5) tick();
        check_val("t4_gnt_wait", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        set_ops(1, 4'd7, 4'd6);
        bus.req = 4'b0010;
        rst_n = 1'b0;
        #1;
        check_val("t4_rst_outputs", all_outs(), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        clear_log();
        n = 0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            tick();
            n++;
            if (bus.gnt != '0) seen = 1'b1;
        end
        check_val("t4_first_gnt_cyc", 32'(n), 32'd11);
        check_val("t4_gnt_owner", 32'(bus.gnt), 32'h2);
        wait_resp(1, 40, "t4_resp_tmo");
        check_val("t4_idx", 32'(idx_at(0)), 32'd1);
        check_val("t4_result", 32'(res_at(0)), 32'h2A);
        check_val("t4_nresp", 32'(q_idx.size()), 32'd1);
        tick();

        // Multiplier never answers
        clear_log();
        m_mute = 1'b1;
        set_ops(3, 4'd2, 4'd2);
        t0 = cyc;
        bus.req = 4'b1000;
`ifdef MULT_ARB_TIMEOUT_EN
        wait_resp(1, 60, "t5_resp_tmo");
        check_val("t5_idx", 32'(idx_at(0)), 32'd3);
        check_val("t5_err", 32'(err_at(0)), 32'd1);
        check_val("t5_result", 32'(res_at(0)), 32'h00);
        check_val("t5_latency", 32'(cyc_at(0) - t0), 32'd18);
        m_mute = 1'b0;
        tick();
        clear_log();
        set_ops(0, 4'd3, 4'd3);
        bus.req = 4'b0001;
        wait_resp(1, 60, "t5_recover_tmo");
        check_val("t5_recover_idx", 32'(idx_at(0)), 32'd0);
        check_val("t5_recover_res", 32'(res_at(0)), 32'h09);
        check_val("t5_recover_err", 32'(err_at(0)), 32'd0);
        tick();
`else
        repeat (40) tick();
        check_val("t5_no_resp", 32'(q_idx.size()), 32'd0);
        check_val("t5_gnt_held", 32'(bus.gnt), 32'h8);
        m_mute = 1'b0;
        bus.req = '0;
        do_reset();
        repeat (12) tick();
`endif

        // Zero operands
        clear_log();
        st_cnt = 0;
        set_ops(2, 4'd0, 4'd9);
        bus.req = 4'b0100;
        wait_resp(1, 40, "t6a_resp_tmo");
        check_val("t6a_idx", 32'(idx_at(0)), 32'd2);
        check_val("t6a_result", 32'(res_at(0)), 32'h00);
        tick();
        set_ops(1, 4'd15, 4'd0);
        bus.req = 4'b0010;
        wait_resp(2, 40, "t6b_resp_tmo");
        check_val("t6b_idx", 32'(idx_at(1)), 32'd1);
        check_val("t6b_result", 32'(res_at(1)), 32'h00);
        tick();
        check_val("t6_st_pulses", 32'(st_cnt), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
